// File: rtl/led_pwm_ctrl.sv
// LED pad driver: prescaled 8-bit PWM dimming, optional blinking and pad polarity,
// with pattern/config shadowed on PWM period boundaries. Blink logic built only when LED_PWM_BLINK_EN is defined.
`timescale 1ns/1ps

module led_pwm_ctrl #(
  parameter int unsigned PRESCALE       = 100,
  parameter int unsigned APB_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [3:0]                led_pattern,
  input  logic [APB_DATA_WIDTH-1:0] led_cfg,
  output logic [3:0]                led_pad,
  output logic                      period_strobe
);

  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  logic             en_c;
  logic             tick_c;
  logic             bound_c;
  logic             load_c;
  logic             lit_c;
  logic             phase_c;
  logic             cfg_unused_c;

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [3:0]       pat_sh_q, pat_sh_d;
  logic [7:0]       duty_sh_q, duty_sh_d;
  logic             pol_sh_q, pol_sh_d;
  logic [3:0]       led_pad_q, led_pad_d;
  logic             period_strobe_q, period_strobe_d;

  // Only selected config bits are used; the rest are deliberately dropped.
  assign cfg_unused_c = ^led_cfg;

  assign en_c    = led_cfg[16];
  assign tick_c  = en_c && (psc_q == PSC_MAX);
  assign bound_c = tick_c && (pwm_cnt_q == 8'hFF);
  // Shadows are transparent while disabled so enabling starts from the latest inputs.
  assign load_c  = !en_c || bound_c;
  assign lit_c   = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);

  // Prescaler, PWM counter and shadow registers
  always_comb begin
    psc_d     = psc_q;
    pwm_cnt_d = pwm_cnt_q;
    pat_sh_d  = pat_sh_q;
    duty_sh_d = duty_sh_q;
    pol_sh_d  = pol_sh_q;
    if (!en_c) begin
      psc_d     = '0;
      pwm_cnt_d = 8'd0;
    end else if (tick_c) begin
      psc_d     = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      psc_d     = psc_q + PSC_W'(1);
    end
    if (load_c) begin
      pat_sh_d  = led_pattern;
      duty_sh_d = led_cfg[7:0];
      pol_sh_d  = led_cfg[17];
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [7:0] blink_sh_q, blink_sh_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       phase_q, phase_d;

  // Blink half-period counter; a new blink value restarts in the visible phase.
  always_comb begin
    blink_sh_d = load_c ? led_cfg[15:8] : blink_sh_q;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    if (!en_c || (blink_sh_q == 8'd0)) begin
      bcnt_d  = 8'd0;
      phase_d = 1'b0;
    end else if (bound_c) begin
      if (led_cfg[15:8] != blink_sh_q) begin
        bcnt_d  = 8'd0;
        phase_d = 1'b0;
      end else if (bcnt_q == (blink_sh_q - 8'd1)) begin
        bcnt_d  = 8'd0;
        phase_d = !phase_q;
      end else begin
        bcnt_d  = bcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_sh_q <= 8'd0;
      bcnt_q     <= 8'd0;
      phase_q    <= 1'b0;
    end else begin
      blink_sh_q <= blink_sh_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
    end
  end

  assign phase_c = phase_q;
`else
  assign phase_c = 1'b0;
`endif

  // Pad drive: off state follows the live polarity while disabled.
  always_comb begin
    led_pad_d       = {4{led_cfg[17]}};
    period_strobe_d = bound_c;
    if (en_c) begin
      led_pad_d = (pat_sh_q & {4{lit_c & ~phase_c}}) ^ {4{pol_sh_q}};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      psc_q           <= '0;
      pwm_cnt_q       <= 8'd0;
      pat_sh_q        <= 4'd0;
      duty_sh_q       <= 8'd0;
      pol_sh_q        <= 1'b0;
      led_pad_q       <= 4'd0;
      period_strobe_q <= 1'b0;
    end else begin
      psc_q           <= psc_d;
      pwm_cnt_q       <= pwm_cnt_d;
      pat_sh_q        <= pat_sh_d;
      duty_sh_q       <= duty_sh_d;
      pol_sh_q        <= pol_sh_d;
      led_pad_q       <= led_pad_d;
      period_strobe_q <= period_strobe_d;
    end
  end

  assign led_pad       = led_pad_q;
  assign period_strobe = period_strobe_q;

endmodule
